// File: rtl/ps2_host_tx_pkg.sv
// ============================================================================
// Module : ps2_host_tx_pkg
// Brief  : State encoding, PS/2 command constants and widths shared by the
//          PS/2 host transmitter and the receiver side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] c_CMD_SET_LED = 8'hED;
    localparam logic [7:0] c_CMD_RESET   = 8'hFF;
    localparam logic [7:0] c_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] c_RSP_ACK     = 8'hFA;

    localparam int c_CNT_W = 20;
    localparam int c_BIT_W = 4;

    // Falls counted in SEND before the stop bit is released.
    localparam logic [c_BIT_W-1:0] c_LAST_DATA_FALL = 4'd9;

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
// ============================================================================
// Module : ps2_host_tx_line_sync
// Brief  : Two-flop synchroniser for the PS/2 clock and data lines plus a
//          one-cycle pulse on each synchronised clock falling edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_host_tx_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fall
);

    logic [1:0] r_meta_q;
    logic [1:0] r_sync_q;
    logic       r_clk_prev_q;

    // Idle bus level is high, so the chain resets to 1 to avoid a false fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q     <= 2'b11;
            r_sync_q     <= 2'b11;
            r_clk_prev_q <= 1'b1;
        end else begin
            r_meta_q     <= {i_ps2_data, i_ps2_clk};
            r_sync_q     <= r_meta_q;
            r_clk_prev_q <= r_sync_q[0];
        end
    end

    assign o_clk_sync  = r_sync_q[0];
    assign o_data_sync = r_sync_q[1];
    assign o_clk_fall  = r_clk_prev_q & ~r_sync_q[0];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module : ps2_host_tx
// Brief  : Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked
//          out 8 data bits + odd parity + stop, then checks the device ACK.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int REQ_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REQ_LAST     = c_CNT_W'(REQ_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT      = c_CNT_W'(TIMEOUT_CYCLES);

    ps2_tx_state_e        r_state_q,    w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q,      w_cnt_d;
    logic [c_BIT_W-1:0]   r_bit_cnt_q,  w_bit_cnt_d;
    logic [8:0]           r_shift_q,    w_shift_d;
    logic                 r_data_low_q, w_data_low_d;

    logic                 w_clk_sync;
    logic                 w_data_sync;
    logic                 w_clk_fall;
    logic                 w_done;
    logic                 w_error;
    logic                 w_timeout;
    logic [c_CNT_W-1:0]   w_cnt_inc;

    ps2_host_tx_line_sync u_line_sync (
        .clk         (clock),
        .rst         (reset),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_data  (ps2_data_in),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_clk_fall  (w_clk_fall)
    );

    assign w_cnt_inc = r_cnt_q + {{(c_CNT_W-1){1'b0}}, 1'b1};
    assign w_timeout = (r_cnt_q == c_TIMEOUT);

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_shift_d    = r_shift_q;
        w_data_low_d = r_data_low_q;
        w_done       = 1'b0;
        w_error      = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_shift_d = {~^tx_data, tx_data};
                    w_cnt_d   = '0;
                    w_state_d = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (r_cnt_q == c_INHIBIT_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_REQ;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            ST_REQ: begin
                if (r_cnt_q == c_REQ_LAST) begin
                    w_cnt_d      = '0;
                    w_bit_cnt_d  = '0;
                    w_data_low_d = 1'b1;
                    w_state_d    = ST_SEND;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            // Each device fall presents the next bit; the tenth releases data (stop).
            ST_SEND: begin
                if (w_clk_fall) begin
                    w_cnt_d = '0;
                    if (r_bit_cnt_q == c_LAST_DATA_FALL) begin
                        w_data_low_d = 1'b0;
                        w_state_d    = ST_ACK;
                    end else begin
                        w_data_low_d = ~r_shift_q[0];
                        w_shift_d    = {1'b0, r_shift_q[8:1]};
                        w_bit_cnt_d  = r_bit_cnt_q + 4'd1;
                    end
                end else if (w_timeout) begin
                    w_data_low_d = 1'b0;
                    w_error      = 1'b1;
                    w_state_d    = ST_IDLE;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            ST_ACK: begin
                if (w_clk_fall) begin
                    w_cnt_d = '0;
                    if (w_data_sync) begin
                        w_error   = 1'b1;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_state_d = ST_WAIT_IDLE;
                    end
                end else if (w_timeout) begin
                    w_error   = 1'b1;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            ST_WAIT_IDLE: begin
                if (w_clk_sync && w_data_sync) begin
                    w_done    = 1'b1;
                    w_state_d = ST_IDLE;
                end else if (w_clk_fall) begin
                    w_cnt_d = '0;
                end else if (w_timeout) begin
                    w_error   = 1'b1;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            default: begin
                w_data_low_d = 1'b0;
                w_state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= '0;
            r_bit_cnt_q  <= '0;
            r_shift_q    <= '0;
            r_data_low_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_shift_q    <= w_shift_d;
            r_data_low_q <= w_data_low_d;
        end
    end

    // Line drives decode straight from state so any exit to IDLE releases the bus.
    assign ps2_clk_drive_low  = (r_state_q == ST_INHIBIT) || (r_state_q == ST_REQ);
    assign ps2_data_drive_low = (r_state_q == ST_REQ) ||
                                ((r_state_q == ST_SEND) && r_data_low_q);

    assign tx_ready = (r_state_q == ST_IDLE);
    assign busy     = (r_state_q != ST_IDLE);
    assign tx_done  = w_done;
    assign tx_error = w_error;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module : tb_ps2_host_tx
// Brief  : Bench for ps2_host_tx with a cycle-level PS/2 keyboard model and a
//          frame-level reference (start, LSB-first data, odd parity, stop).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int c_INH  = 20;
    localparam int c_REQ  = 4;
    localparam int c_TMO  = 2000;
    localparam int c_HALF = 20;

    localparam int c_MODE_ACK     = 0;
    localparam int c_MODE_NACK    = 1;
    localparam int c_MODE_SILENT  = 2;
    localparam int c_MODE_RST_MID = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_line  = ~(ps2_clk_drive_low  | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_drive_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INH),
        .REQ_CYCLES     (c_REQ),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clock              (clk),
        .reset              (rst),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .tx_done            (tx_done),
        .tx_error           (tx_error),
        .busy               (busy),
        .ps2_clk_in         (ps2_clk_line),
        .ps2_data_in        (ps2_data_line),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected 11-bit frame as the device reads it: bit0 start ... bit10 stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f    = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones  += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Pulse monitor: exclusivity, ready low during pulse, ready high after it.
    initial begin
        logic prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_pulse && !rst)
                check_eq("ready_after_pulse", 32'(tx_ready), 32'd1);
            if (tx_done || tx_error) begin
                check_eq("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
                check_eq("ready_during_pulse", 32'(tx_ready), 32'd0);
            end
            done_cnt  += int'(tx_done);
            err_cnt   += int'(tx_error);
            prev_pulse = tx_done | tx_error;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic offer(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Keyboard model: measures inhibit/request phases, then clocks the frame.
    task automatic dev_frame(input int mode, input string tag, output logic [10:0] got);
        int n;
        got = '0;
        n = 0;
        while (!ps2_clk_drive_low && n < 100) begin @(negedge clk); n++; end
        if (!ps2_clk_drive_low) begin
            check_eq({tag, "_inhibit_start"}, 32'(ps2_clk_drive_low), 32'd1);
            return;
        end
        n = 0;
        while (ps2_clk_drive_low && !ps2_data_drive_low && n < 1000) begin @(negedge clk); n++; end
        check_eq({tag, "_inhibit_len"}, 32'(n), 32'(c_INH));
        n = 0;
        while (ps2_clk_drive_low && ps2_data_drive_low && n < 1000) begin @(negedge clk); n++; end
        check_eq({tag, "_req_len"}, 32'(n), 32'(c_REQ));
        check_eq({tag, "_start_drive"}, 32'(ps2_data_drive_low), 32'd1);

        if (mode == c_MODE_SILENT) begin
            n = 0;
            while (!tx_error && n < c_TMO + 50) begin @(negedge clk); n++; end
            check_eq({tag, "_timeout_cycles"}, 32'(n), 32'(c_TMO));
            @(negedge clk);
            check_eq({tag, "_tmo_clk_rel"},  32'(ps2_clk_drive_low),  32'd0);
            check_eq({tag, "_tmo_data_rel"}, 32'(ps2_data_drive_low), 32'd0);
            return;
        end

        repeat (10) @(negedge clk);
        got[0] = ps2_data_line;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (c_HALF) @(negedge clk);
            if (mode == c_MODE_RST_MID && k == 5) begin
                rst = 1'b1;
                @(negedge clk);
                check_eq({tag, "_rst_clk_rel"},  32'(ps2_clk_drive_low),  32'd0);
                check_eq({tag, "_rst_data_rel"}, 32'(ps2_data_drive_low), 32'd0);
                check_eq({tag, "_rst_ready"},    32'(tx_ready),           32'd1);
                rst         = 1'b0;
                dev_clk_low = 1'b0;
                repeat (5) @(negedge clk);
                return;
            end
            dev_clk_low = 1'b0;
            if (k <= 10) got[k] = ps2_data_line;
            if (k == 10 && mode == c_MODE_ACK) begin
                repeat (2) @(negedge clk);
                dev_data_low = 1'b1;
                repeat (c_HALF - 2) @(negedge clk);
            end else begin
                repeat (c_HALF) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b, input int mode, input string tag, input bit poke);
        int          d0, e0, n;
        logic [10:0] got;
        d0 = done_cnt;
        e0 = err_cnt;
        offer(b);
        if (poke) begin
            fork
                dev_frame(mode, tag, got);
                begin
                    repeat (60) @(negedge clk);
                    tx_data  = 8'h00;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            join
        end else begin
            dev_frame(mode, tag, got);
        end
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 60 && mode != c_MODE_RST_MID) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq({tag, "_done"},  32'(done_cnt - d0), (mode == c_MODE_ACK) ? 32'd1 : 32'd0);
        check_eq({tag, "_error"}, 32'(err_cnt - e0),
                 (mode == c_MODE_NACK || mode == c_MODE_SILENT) ? 32'd1 : 32'd0);
        if (mode == c_MODE_ACK || mode == c_MODE_NACK)
            check_eq({tag, "_frame"}, 32'(got), 32'(exp_frame(b)));
        check_eq({tag, "_clk_rel"},  32'(ps2_clk_drive_low),  32'd0);
        check_eq({tag, "_data_rel"}, 32'(ps2_data_drive_low), 32'd0);
        check_eq({tag, "_ready"},    32'(tx_ready),           32'd1);
    endtask

    initial begin
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        check_eq("rst_ready",    32'(tx_ready),           32'd1);
        check_eq("rst_busy",     32'(busy),               32'd0);
        check_eq("rst_clk_drv",  32'(ps2_clk_drive_low),  32'd0);
        check_eq("rst_data_drv", 32'(ps2_data_drive_low), 32'd0);
        check_eq("rst_pulses",   32'({tx_done, tx_error}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(c_CMD_SET_LED, c_MODE_ACK, "led", 1'b0);
        run_frame(8'h07,         c_MODE_ACK, "x07", 1'b0);
        run_frame(c_CMD_RESET,   c_MODE_ACK, "xff", 1'b0);
        for (int i = 0; i < 5; i++) begin
            rb = 8'($urandom);
            run_frame(rb, c_MODE_ACK, "rand", 1'b0);
        end
        run_frame(8'hA5, c_MODE_NACK,    "nack",    1'b0);
        run_frame(8'h3C, c_MODE_SILENT,  "timeout", 1'b0);
        run_frame(8'h55, c_MODE_RST_MID, "midrst",  1'b0);
        run_frame(c_CMD_ENABLE, c_MODE_ACK, "enable", 1'b0);
        run_frame(8'h96, c_MODE_ACK, "busy_poke", 1'b1);
        run_frame(c_CMD_SET_LED, c_MODE_ACK, "b2b_a", 1'b0);
        run_frame(8'h02,         c_MODE_ACK, "b2b_b", 1'b0);

        repeat (5) @(negedge clk);
        check_eq("final_idle", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
